// File: rtl/py_seq_pkg.sv
// rtl/py_seq_pkg.sv - packet type codes, sequencer states, error codes and type table lookup
package py_seq_pkg;

    localparam logic [3:0] PK_NULL = 4'h0;
    localparam logic [3:0] PK_POLL = 4'h1;
    localparam logic [3:0] PK_FHS  = 4'h2;
    localparam logic [3:0] PK_DM1  = 4'h3;
    localparam logic [3:0] PK_DH1  = 4'h4;
    localparam logic [3:0] PK_HV1  = 4'h5;
    localparam logic [3:0] PK_HV2  = 4'h6;
    localparam logic [3:0] PK_HV3  = 4'h7;
    localparam logic [3:0] PK_3DH1 = 4'h8;
    localparam logic [3:0] PK_AUX1 = 4'h9;
    localparam logic [3:0] PK_DM3  = 4'hA;
    localparam logic [3:0] PK_DH3  = 4'hB;
    localparam logic [3:0] PK_DM5  = 4'hE;
    localparam logic [3:0] PK_DH5  = 4'hF;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_TYPE = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN, ST_DONE} seq_state_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] hdr;
        logic       fec13;
        logic       fec23;
        logic       crc;
        logic       brss;
        logic       fixed;
        logic [7:0] fix_bits;
        logic [9:0] max_b;
    } type_rec_t;

    // EDR codes only override their BR meaning when edr is set; all else falls back to BR
    function automatic type_rec_t type_lookup(input logic [3:0] t, input logic edr);
        type_rec_t r;
        r    = '0;
        r.ok = 1'b1;
        if (edr && (t == PK_DH1 || t == PK_3DH1 || t == PK_DM3 || t == PK_DH3 ||
                    t == PK_DM5 || t == PK_DH5)) begin
            r.hdr = 2'd2;
            r.crc = 1'b1;
            case (t)
                PK_DH1:  r.max_b = 10'd54;
                PK_3DH1: r.max_b = 10'd83;
                PK_DM3:  r.max_b = 10'd367;
                PK_DH3:  r.max_b = 10'd552;
                PK_DM5:  r.max_b = 10'd679;
                default: r.max_b = 10'd1021;
            endcase
        end else begin
            case (t)
                PK_NULL, PK_POLL: r.ok = 1'b1;
                PK_FHS:  begin r.fec23 = 1'b1; r.crc = 1'b1; r.brss = 1'b1; r.fixed = 1'b1; r.fix_bits = 8'd144; end
                PK_DM1:  begin r.hdr = 2'd1; r.fec23 = 1'b1; r.crc = 1'b1; r.brss = 1'b1; r.max_b = 10'd17; end
                PK_DH1:  begin r.hdr = 2'd1; r.crc = 1'b1; r.brss = 1'b1; r.max_b = 10'd27; end
                PK_HV1:  begin r.fec13 = 1'b1; r.fixed = 1'b1; r.fix_bits = 8'd80; end
                PK_HV2:  begin r.fec23 = 1'b1; r.fixed = 1'b1; r.fix_bits = 8'd160; end
                PK_HV3:  begin r.fixed = 1'b1; r.fix_bits = 8'd240; end
                PK_AUX1: begin r.hdr = 2'd1; r.brss = 1'b1; r.max_b = 10'd29; end
                PK_DM3:  begin r.hdr = 2'd2; r.fec23 = 1'b1; r.crc = 1'b1; r.max_b = 10'd121; end
                PK_DH3:  begin r.hdr = 2'd2; r.crc = 1'b1; r.max_b = 10'd183; end
                PK_DM5:  begin r.hdr = 2'd2; r.fec23 = 1'b1; r.crc = 1'b1; r.max_b = 10'd224; end
                PK_DH5:  begin r.hdr = 2'd2; r.crc = 1'b1; r.max_b = 10'd339; end
                default: r.ok = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/py_seq_ctrl_if.sv
// rtl/py_seq_ctrl_if.sv - sequencer to payload bit processor bundle
interface py_seq_ctrl_if;
    logic        py_st_p;
    logic [3:0]  pk_type;
    logic        pk_encode;
    logic [12:0] pylenbit;
    logic        crcencode;
    logic        fec31encode;
    logic        fec32encode;
    logic        existpyheader;
    logic        BRss;
    logic        py_period;
    logic        dec_py_period;
    logic [9:0]  dec_pylenByte;
    logic        hdrdec_valid_p;

    modport master (
        output py_st_p, pk_type, pk_encode, pylenbit, crcencode, fec31encode,
               fec32encode, existpyheader, BRss,
        input  py_period, dec_py_period, dec_pylenByte, hdrdec_valid_p
    );

    modport slave (
        input  py_st_p, pk_type, pk_encode, pylenbit, crcencode, fec31encode,
               fec32encode, existpyheader, BRss,
        output py_period, dec_py_period, dec_pylenByte, hdrdec_valid_p
    );
endinterface

// File: rtl/py_type_decode.sv
// rtl/py_type_decode.sv - combinational coding flags and clamped pylenbit for a packet type
module py_type_decode
    import py_seq_pkg::*;
#(
    parameter int MAXLEN_BYTE = 339
) (
    input  logic [3:0]  pk_type,
    input  logic        edr,
    input  logic [9:0]  len_byte,
    output logic        crcencode,
    output logic        fec31encode,
    output logic        fec32encode,
    output logic        existpyheader,
    output logic        BRss,
    output logic [12:0] pylenbit
);
    localparam logic [9:0] MAXLEN = 10'(MAXLEN_BYTE);

    type_rec_t  rec;
    logic [9:0] eff;
    logic [9:0] tot;

    always_comb begin
        rec = type_lookup(pk_type, edr);
        eff = len_byte;
        if (eff > rec.max_b) eff = rec.max_b;
        if (eff > MAXLEN)    eff = MAXLEN;
        tot = eff + 10'(rec.hdr);
    end

    assign crcencode     = rec.ok & rec.crc;
    assign fec31encode   = rec.ok & rec.fec13;
    assign fec32encode   = rec.ok & rec.fec23;
    assign existpyheader = rec.ok & (rec.hdr != 2'd0);
    assign BRss          = rec.ok & rec.brss;
    // fixed-size voice/FHS payloads ignore any requested length
    assign pylenbit      = !rec.ok   ? 13'd0 :
                           rec.fixed ? {5'd0, rec.fix_bits} : {tot, 3'b000};
endmodule

// File: rtl/py_seq_ctrl.sv
// rtl/py_seq_ctrl.sv - per-packet payload sequencer; PYSEQ_EDR_EN adds edr_mode and the EDR type table
module py_seq_ctrl
    import py_seq_pkg::*;
#(
    parameter int TMO_US = 3200,
`ifdef PYSEQ_EDR_EN
    parameter int MAXLEN_BYTE = 1021
`else
    parameter int MAXLEN_BYTE = 339
`endif
) (
    input  logic        clk_6M,
    input  logic        rst,
    input  logic        p_1us,
    input  logic        start_p,
    input  logic        tx,
    input  logic [3:0]  pk_type_in,
    input  logic [9:0]  regi_pylenByte,
    input  logic        hdr_done_p,
    input  logic        abort_p,
`ifdef PYSEQ_EDR_EN
    input  logic        edr_mode,
`endif
    py_seq_ctrl_if.master py,
    output logic        busy,
    output logic        py_done_p,
    output logic        err_p,
    output logic [1:0]  err_code
);
    localparam int TW = $clog2(TMO_US + 1);

    seq_state_t    state, state_d;
    logic [3:0]    type_q;
    logic          tx_q, edr_q, edr_in;
    logic [9:0]    len_q;
    logic          seen_hi;
    logic [TW-1:0] tmo_cnt;
    logic          py_st_q, py_st_d, err_d, latch;
    logic [1:0]    code_d;
    logic          win, fall, rx_run, timeout, start_ok, zero_len;

`ifdef PYSEQ_EDR_EN
    assign edr_in = edr_mode;
`else
    assign edr_in = 1'b0;
`endif

    py_type_decode #(.MAXLEN_BYTE(MAXLEN_BYTE)) u_dec (
        .pk_type       (type_q),
        .edr           (edr_q),
        .len_byte      (len_q),
        .crcencode     (py.crcencode),
        .fec31encode   (py.fec31encode),
        .fec32encode   (py.fec32encode),
        .existpyheader (py.existpyheader),
        .BRss          (py.BRss),
        .pylenbit      (py.pylenbit)
    );

    assign start_ok = type_lookup(pk_type_in, edr_in).ok;
    assign zero_len = (py.pylenbit == 13'd0);
    assign win      = tx_q ? py.py_period : py.dec_py_period;
    assign fall     = seen_hi & ~win;
    assign rx_run   = (state == ST_RUN) && !tx_q;
    assign timeout  = rx_run && p_1us && (tmo_cnt == TW'(TMO_US - 1));

    always_comb begin
        state_d = state;
        py_st_d = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code;
        latch   = 1'b0;
        case (state)
            ST_IDLE: if (start_p) begin
                latch = 1'b1;
                if (start_ok) begin
                    state_d = ST_ARMED;
                    code_d  = ERR_NONE;
                end else begin
                    err_d  = 1'b1;
                    code_d = ERR_BAD_TYPE;
                end
            end
            ST_ARMED: if (hdr_done_p) begin
                if (zero_len) state_d = ST_DONE;
                else begin
                    state_d = ST_RUN;
                    py_st_d = 1'b1;
                end
            end
            ST_RUN: if (timeout) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
            end else if (fall) begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        // abort overrides whatever the state decided, including a coincident payload start
        if (abort_p && state != ST_IDLE) begin
            state_d = ST_IDLE;
            py_st_d = 1'b0;
            err_d   = 1'b1;
            code_d  = ERR_ABORT;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state    <= ST_IDLE;
            py_st_q  <= 1'b0;
            err_p    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_d;
            py_st_q  <= py_st_d;
            err_p    <= err_d;
            err_code <= code_d;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            type_q  <= '0;
            tx_q    <= 1'b0;
            edr_q   <= 1'b0;
            len_q   <= '0;
            seen_hi <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            // RX arms with an all-ones length so the clamp yields the type maximum
            if (latch) begin
                type_q <= pk_type_in;
                tx_q   <= tx;
                edr_q  <= edr_in;
                len_q  <= tx ? regi_pylenByte : '1;
            end else if (rx_run && py.hdrdec_valid_p) begin
                len_q  <= py.dec_pylenByte;
            end
            seen_hi <= (state == ST_RUN) && (seen_hi || win);
            if (!rx_run)    tmo_cnt <= '0;
            else if (p_1us) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign py.py_st_p   = py_st_q;
    assign py.pk_type   = type_q;
    assign py.pk_encode = tx_q;
    assign busy         = (state == ST_ARMED) || (state == ST_RUN);
    assign py_done_p    = (state == ST_DONE) && !abort_p;
endmodule

// File: tb/tb_py_seq_ctrl.sv
// tb/tb_py_seq_ctrl.sv - randomized and directed bench for py_seq_ctrl against a packet-level model
module tb_py_seq_ctrl;
    localparam int TMO    = 50;
    localparam int MAXLEN = 339;
    localparam int IDLE = 0, ARMED = 1, RUN = 2, DONE = 3;

    logic clk_6M = 1'b0, rst = 1'b1, p_1us = 1'b0, start_p = 1'b0, tx = 1'b0;
    logic [3:0] pk_type_in = '0;
    logic [9:0] regi_pylenByte = '0;
    logic hdr_done_p = 1'b0, abort_p = 1'b0;
    logic busy, py_done_p, err_p;
    logic [1:0] err_code;

    py_seq_ctrl_if pif();

    py_seq_ctrl #(.TMO_US(TMO)) dut (
        .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us), .start_p(start_p), .tx(tx),
        .pk_type_in(pk_type_in), .regi_pylenByte(regi_pylenByte), .hdr_done_p(hdr_done_p),
        .abort_p(abort_p), .py(pif), .busy(busy), .py_done_p(py_done_p),
        .err_p(err_p), .err_code(err_code)
    );

    always #5 clk_6M = ~clk_6M;

    int hdr_t [16] = '{0,0,0,1,1,0,0,0,0,1,2,2,0,0,2,2};
    int max_t [16] = '{0,0,0,17,27,0,0,0,0,29,121,183,0,0,224,339};
    int fix_t [16] = '{0,0,144,0,0,80,160,240,0,0,0,0,0,0,0,0};
    bit ok_t  [16] = '{1,1,1,1,1,1,1,1,0,1,1,1,0,0,1,1};
    bit crc_t [16] = '{0,0,1,1,1,0,0,0,0,0,1,1,0,0,1,1};
    bit f13_t [16] = '{0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0};
    bit f23_t [16] = '{0,0,1,1,0,0,1,0,0,0,1,0,0,0,1,0};
    bit brs_t [16] = '{0,0,1,1,1,0,0,0,0,1,0,0,0,0,0,0};

    int n_cmp = 0, n_bad = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_plb(input int t, input int len);
        int l;
        if (fix_t[t] != 0) return fix_t[t];
        l = len;
        if (l > max_t[t]) l = max_t[t];
        if (l > MAXLEN)   l = MAXLEN;
        return (hdr_t[t] + l) * 8;
    endfunction

    int  ph, m_type, m_len, m_ticks, e_code;
    bit  m_tx, m_seen, e_st, e_err, m_win;

    initial forever begin
        @(posedge clk_6M);
        if (rst) begin
            ph = IDLE; m_type = 0; m_len = 0; m_tx = 0; e_st = 0; e_err = 0; e_code = 0;
        end else begin
            m_win = m_tx ? pif.py_period : pif.dec_py_period;
            e_st = 0; e_err = 0;
            case (ph)
                IDLE: if (start_p) begin
                    m_type = int'(pk_type_in); m_tx = tx;
                    m_len  = tx ? int'(regi_pylenByte) : max_t[m_type];
                    if (ok_t[m_type]) begin ph = ARMED; e_code = 0; end
                    else begin e_err = 1; e_code = 1; end
                end
                ARMED: if (abort_p) begin ph = IDLE; e_err = 1; e_code = 3; end
                    else if (hdr_done_p) begin
                        if (m_plb(m_type, m_len) == 0) ph = DONE;
                        else begin ph = RUN; e_st = 1; m_seen = 0; m_ticks = 0; end
                    end
                RUN: begin
                    if (!m_tx && pif.hdrdec_valid_p) m_len = int'(pif.dec_pylenByte);
                    if (abort_p) begin ph = IDLE; e_err = 1; e_code = 3; end
                    else if (!m_tx && p_1us && m_ticks + 1 == TMO) begin ph = IDLE; e_err = 1; e_code = 2; end
                    else if (m_seen && !m_win) ph = DONE;
                    else begin
                        m_seen = m_seen | m_win;
                        if (!m_tx && p_1us) m_ticks++;
                    end
                end
                default: begin
                    if (abort_p) begin e_err = 1; e_code = 3; end
                    ph = IDLE;
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk_6M);
        if (cmp_en) begin
            chk("busy", busy, (ph == ARMED || ph == RUN));
            chk("py_done_p", py_done_p, (ph == DONE && !abort_p));
            chk("py_st_p", pif.py_st_p, e_st);
            chk("err_p", err_p, e_err);
            chk("err_code", err_code, e_code);
            chk("pk_type", pif.pk_type, m_type);
            chk("pk_encode", pif.pk_encode, m_tx);
            chk("pylenbit", pif.pylenbit, m_plb(m_type, m_len));
            chk("crcencode", pif.crcencode, crc_t[m_type]);
            chk("fec31encode", pif.fec31encode, f13_t[m_type]);
            chk("fec32encode", pif.fec32encode, f23_t[m_type]);
            chk("existpyheader", pif.existpyheader, hdr_t[m_type] > 0);
            chk("BRss", pif.BRss, brs_t[m_type]);
        end
    end

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk_6M); #1;
            p_1us = (c == 5);
            c = (c + 1) % 6;
        end
    end

    task automatic cyc();
        @(posedge clk_6M); #1;
        start_p = 0; hdr_done_p = 0; abort_p = 0; pif.hdrdec_valid_p = 0;
    endtask

    task automatic arm(input int t, input bit dir, input int len);
        pk_type_in = 4'(t); tx = dir; regi_pylenByte = 10'(len); start_p = 1;
        cyc();
    endtask

    task automatic rand_pkt();
        int t, n;
        bit dir;
        t = $urandom_range(0, 15); dir = 1'($urandom_range(0, 1));
        arm(t, dir, $urandom_range(0, 400));
        repeat ($urandom_range(0, 3)) begin
            if ($urandom_range(0, 2) == 0) begin
                start_p = 1; pk_type_in = 4'($urandom_range(0, 15)); tx = 1'($urandom_range(0, 1));
            end
            cyc();
        end
        hdr_done_p = 1;
        if ($urandom_range(0, 9) == 0) abort_p = 1;
        cyc();
        repeat ($urandom_range(0, 3)) cyc();
        n = ($urandom_range(0, 15) == 0) ? 330 : $urandom_range(1, 20);
        for (int i = 0; i < n; i++) begin
            if (dir) begin pif.py_period = 1; pif.dec_py_period = 1'($urandom_range(0, 1)); end
            else     begin pif.dec_py_period = 1; pif.py_period = 1'($urandom_range(0, 1)); end
            if (!dir && i == 1) begin pif.hdrdec_valid_p = 1; pif.dec_pylenByte = 10'($urandom_range(0, 1023)); end
            if ($urandom_range(0, 99) == 0) abort_p = 1;
            if ($urandom_range(0, 19) == 0) hdr_done_p = 1;
            cyc();
        end
        pif.py_period = 0; pif.dec_py_period = 0;
        repeat ($urandom_range(1, 4)) cyc();
    endtask

    initial begin
        int i;
        pif.py_period = 0; pif.dec_py_period = 0; pif.dec_pylenByte = '0; pif.hdrdec_valid_p = 0;
        @(posedge clk_6M); #1;
        cmp_en = 1;
        repeat (2) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_pylenbit", pif.pylenbit, 0);
        chk("rst_err_code", err_code, 0);
        rst = 0;
        cyc();

        chk("model_dh1_20", m_plb(4, 20), 168);
        chk("model_dm1_40", m_plb(3, 40), 144);
        chk("model_dh5_max", m_plb(15, 1023), 2728);
        chk("model_hv2", m_plb(6, 9), 160);

        arm(4, 1, 20);
        chk("dh1_busy", busy, 1);
        chk("dh1_pylenbit", pif.pylenbit, 168);
        chk("dh1_crc", pif.crcencode, 1);
        chk("dh1_fec", {pif.fec31encode, pif.fec32encode}, 0);
        chk("dh1_brss", pif.BRss, 1);
        hdr_done_p = 1; cyc();
        chk("dh1_py_st", pif.py_st_p, 1);
        pif.py_period = 1; repeat (5) cyc();
        pif.py_period = 0; cyc();
        chk("dh1_done", py_done_p, 1);
        cyc();

        arm(3, 1, 40);
        chk("dm1_pylenbit", pif.pylenbit, 144);
        chk("dm1_fec32", pif.fec32encode, 1);
        hdr_done_p = 1; cyc();
        pif.py_period = 1; repeat (3) cyc();
        pif.py_period = 0; repeat (3) cyc();

        arm(15, 0, 0);
        chk("dh5_rx_pylenbit", pif.pylenbit, 2728);
        hdr_done_p = 1; cyc();
        pif.dec_py_period = 1; pif.hdrdec_valid_p = 1; pif.dec_pylenByte = 10'd100; cyc();
        chk("dh5_reload", pif.pylenbit, 816);
        repeat (3) cyc();
        pif.dec_py_period = 0; cyc();
        chk("dh5_done", py_done_p, 1);
        cyc();

        arm(12, 1, 5);
        chk("bad_err_p", err_p, 1);
        chk("bad_code", err_code, 1);
        chk("bad_busy", busy, 0);
        cyc();

        arm(10, 0, 0);
        hdr_done_p = 1; cyc();
        pif.dec_py_period = 1;
        for (i = 0; i < 400 && !err_p; i++) cyc();
        chk("tmo_err_p", err_p, 1);
        chk("tmo_code", err_code, 2);
        pif.dec_py_period = 0; repeat (2) cyc();

        arm(4, 1, 10);
        hdr_done_p = 1; abort_p = 1; cyc();
        chk("abort_py_st", pif.py_st_p, 0);
        chk("abort_code", err_code, 3);
        chk("abort_busy", busy, 0);
        arm(1, 1, 0);
        hdr_done_p = 1; cyc();
        chk("poll_done", py_done_p, 1);
        chk("poll_py_st", pif.py_st_p, 0);
        repeat (2) cyc();

        for (int k = 0; k < 150; k++) rand_pkt();
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/py_seq_ctrl.md
Name: py_seq_ctrl

Overview:
- Sequences the payload bit processor for one packet at a time: decodes packet type, drives payload length and coding flags, issues the payload start pulse and reports completion.
- Sits between the link/slot controller (start request, packet type) and the payload bit processor (py_st_p, pylenbit, crcencode/fec31encode/fec32encode, existpyheader, BRss, pk_encode).
- Serves both directions. For RX it also rewrites pylenbit once the payload header length has been decoded.

Parameters:
- TMO_US, 3200, RX payload watchdog limit in p_1us ticks.
- MAXLEN_BYTE, 339, clamp for any payload byte length.

Ports:
- clk_6M  in  1  6 MHz clock
- rst  in  1  synchronous active-high reset
- p_1us  in  1  1 us tick, watchdog time base
- start_p  in  1  arm request from slot controller; ignored unless IDLE
- tx  in  1  direction latched at start_p: 1=TX (pk_encode), 0=RX
- pk_type_in  in  4  packet type latched at start_p
- regi_pylenByte  in  10  TX user payload bytes, latched at start_p
- hdr_done_p  in  1  packet header complete; triggers payload start
- py_period  in  1  TX payload window from bit processor
- dec_py_period  in  1  RX decode window from bit processor
- dec_pylenByte  in  10  decoded payload-header length
- hdrdec_valid_p  in  1  dec_pylenByte valid pulse
- abort_p  in  1  slot controller abort
- py_st_p  out  1  one-cycle payload start
- pk_type  out  4  latched type
- pk_encode  out  1  latched tx
- pylenbit  out  13  payload bits excluding CRC
- crcencode, fec31encode, fec32encode, existpyheader, BRss  out  1 each  coding flags for latched type
- busy  out  1  high from armed until done
- py_done_p  out  1  one-cycle completion
- err_p  out  1  one-cycle error: unsupported type, timeout or abort
- err_code  out  2  0 none, 1 bad type, 2 timeout, 3 abort; held until next start_p

Behaviour:
- Reset (synchronous, rst=1 at clock edge): all outputs 0, FSM to IDLE, all counters 0.
- Type table, combinational from latched pk_type: {hdr bytes, fec, crc, max bytes}.
  - FHS=2: 0 hdr, fec23, crc, fixed 144 bits, BRss=1.
  - DM1=3: 1 hdr, fec23, crc, max 17.
  - DH1=4: 1 hdr, none, crc, max 27.
  - HV1=5: fec13, fixed 80 bits.
  - HV2=6: fec23, fixed 160 bits.
  - HV3=7: none, fixed 240 bits.
  - AUX1=9: 1 hdr, none, no crc, max 29.
  - DM3=A: 2 hdr, fec23, crc, max 121.
  - DH3=B: 2 hdr, none, crc, max 183.
  - DM5=E: 2 hdr, fec23, crc, max 224.
  - DH5=F: 2 hdr, none, crc, max 339.
  - NULL=0, POLL=1: zero-length payload.
  - All other codes: unsupported.
  - BRss=1 for 1-byte-header types.
  - existpyheader=1 when hdr bytes > 0.
- Length rule:
  - pylenbit = (hdr + min(len, max, MAXLEN_BYTE)) * 8, 13-bit; fixed types ignore len.
  - TX uses regi_pylenByte.
  - RX starts at hdr + max. On hdrdec_valid_p in RXPY, it is reloaded with the clamped dec_pylenByte within 1 cycle.
- FSM states: IDLE, ARMED, RUN, DONE.
  - IDLE --start_p--> ARMED.
    - Latch type, tx, len; busy=1.
    - Unsupported type: err_p=1, err_code=1, go directly to IDLE without asserting py_st_p.
  - ARMED --hdr_done_p--> RUN; py_st_p asserted exactly the cycle after hdr_done_p.
    - Zero-length payload: no py_st_p; go to DONE.
  - RUN:
    - TX: wait for py_period rise then fall.
    - RX: wait for dec_py_period rise then fall.
    - On the fall go to DONE.
  - DONE: py_done_p=1 for one cycle, busy=0, then IDLE.
  - Total latency, fall of window to py_done_p: 1 cycle.
- Watchdog (RX RUN only): counts p_1us ticks. At TMO_US: err_p, err_code=2, return to IDLE without py_done_p.
- abort_p in any non-IDLE state, priority over all other events:
  - err_p, err_code=3, IDLE next cycle.
  - py_st_p is suppressed if abort_p coincides with hdr_done_p.
- start_p while busy is ignored.
- hdr_done_p outside ARMED is ignored.
- Outputs pk_type, pylenbit and the coding flags stay stable from start_p until the next start_p.

Optional Feature:
- PYSEQ_EDR_EN defined: types are interpreted as EDR when an extra input edr_mode=1. Table adds:
  - 2-DH1=4 / 3-DH1=8: max 54/83.
  - 2-DH3=A / 3-DH3=B: max 367/552.
  - 2-DH5=E / 3-DH5=F: max 679/1021.
  - All with 2 hdr bytes, crc, no fec; BRss=0.
  - MAXLEN_BYTE default becomes 1021.
- Undefined: edr_mode port absent; BR table only.

Decomposition:
- Package py_seq_pkg: packet-type codes, FSM state enum, err_code constants, type-table record (hdr, fec, crc, max) and its lookup function.
- One sub-module, py_type_decode: combinational table returning flags and clamped pylenbit.

Test Plan:
- TX DH1, regi_pylenByte=20, start_p, hdr_done_p → py_st_p next cycle; pylenbit=168; crcencode=1, fec flags 0, BRss=1; py_done_p 1 cycle after py_period fall.
- TX DM1, len=40 → clamped: pylenbit=144, fec32encode=1.
- RX DH5: pylenbit=2728 initially; hdrdec_valid_p with dec_pylenByte=100 → pylenbit=816 next cycle; py_done_p on dec_py_period fall.
- Unsupported type 0xC → err_p, err_code=1, no py_st_p, busy=0.
- RX DM3, TMO_US=50, dec_py_period never falls → err_code=2 after 50 p_1us ticks; no py_done_p.
- abort_p coinciding with hdr_done_p → no py_st_p, err_code=3; then POLL start → py_done_p with no py_st_p.
